spi_draw_decoder: RTL and testbench

- Upstream stage of the pixel store: receives draw commands from the MCU over SPI (mode 0, MSB first) and issues single-pixel write requests to pixelStore.
- Raw pad signals are sampled in the system clock domain. The block assembles 4-byte packets, validates them and presents x, y, newColor and brush with a one-cycle ready strobe.

---
 rtl/spi_draw_decoder.sv | 161 ++++++++++++++++
 tb/tb_spi_draw_decoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_draw_decoder.sv
// SPI (mode 0, MSB first) draw-command receiver: assembles 4-byte packets from
// synchronised pad signals, validates them and strobes one pixel write per good packet.
module spi_draw_decoder #(
  parameter int unsigned XMAX     = 640,
  parameter int unsigned YMAX     = 480,
  parameter logic [1:0]  SYNC_HDR = 2'b10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       sdi,
  input  logic       cs,
  output logic       sdo,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [2:0] newColor,
  output logic       brush,
  output logic       ready,
  output logic       error,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CHECK   = 2'd2,
    DISCARD = 2'd3
  } state_t;

  localparam logic [10:0] X_LIM = XMAX[10:0];
  localparam logic [10:0] Y_LIM = YMAX[10:0];

  // Two synchroniser flops per pad; the extra third stage on sck/cs only feeds edge detection.
  logic [2:0] sck_sync_q;
  logic [2:0] cs_sync_q;
  logic [1:0] sdi_sync_q;

  always_ff @(posedge clk) begin
    sck_sync_q <= {sck_sync_q[1:0], sck};
    cs_sync_q  <= {cs_sync_q[1:0], cs};
    sdi_sync_q <= {sdi_sync_q[0], sdi};
  end

  logic sck_rise;
  logic sck_fall;
  logic cs_fall;
  logic cs_high;

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_high  = cs_sync_q[1];

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] shift_q;
  logic [31:0] shift_d;
  logic [9:0]  x_q;
  logic [9:0]  y_q;
  logic [2:0]  color_q;
  logic        brush_q;
  logic        ready_q;
  logic        error_q;
  logic        sdo_q;

  assign shift_d = {shift_q[30:0], sdi_sync_q[1]};

  logic [9:0] pkt_x;
  logic [9:0] pkt_y;
  logic       pkt_valid;
  logic       unused_rsv;

  assign pkt_x      = {shift_q[23:22], shift_q[15:8]};
  assign pkt_y      = {shift_q[21:20], shift_q[7:0]};
  assign pkt_valid  = (shift_q[31:30] == SYNC_HDR) &&
                      ({1'b0, pkt_x} < X_LIM) && ({1'b0, pkt_y} < Y_LIM);
  assign unused_rsv = ^{shift_q[25:24], shift_q[19:16]};

  // ready is a one-cycle strobe with no backpressure: x/y/newColor/brush are valid
  // in the strobe cycle and hold until the next accepted packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      shift_q <= 32'd0;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      color_q <= 3'd0;
      brush_q <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      sdo_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= 5'd0;
          sdo_q <= 1'b0;
          if (cs_fall) begin
            state_q <= SHIFT;
            sdo_q   <= error_q;
          end
        end
        SHIFT: begin
          if (cs_high) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            sdo_q   <= 1'b0;
          end else if (sck_rise) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state_q <= CHECK;
            end else if (cnt_q == 5'd7 && shift_d[7:6] != SYNC_HDR) begin
              state_q <= DISCARD;
              error_q <= 1'b1;
              sdo_q   <= 1'b0;
            end
          end else if (sck_fall) begin
            // Status byte {error, 7'b0000001}: MSB at packet start, LSB after bit 7.
            sdo_q <= (cnt_q == 5'd0) ? error_q : (cnt_q == 5'd7);
          end
        end
        CHECK: begin
          if (pkt_valid) begin
            x_q     <= pkt_x;
            y_q     <= pkt_y;
            color_q <= shift_q[28:26];
            brush_q <= shift_q[29];
            ready_q <= 1'b1;
            error_q <= 1'b0;
          end else begin
            error_q <= 1'b1;
          end
          if (cs_high) begin
            state_q <= IDLE;
            sdo_q   <= 1'b0;
          end else begin
            state_q <= SHIFT;
          end
        end
        DISCARD: begin
          sdo_q <= 1'b0;
          if (cs_high) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign newColor    = color_q;
  assign brush       = brush_q;
  assign ready       = ready_q;
  assign error       = error_q;
  assign sdo         = sdo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_draw_decoder.sv
// Bench for spi_draw_decoder: drives SPI frames bit by bit and compares pixel strobes,
// held outputs, error flag and the MISO status byte against a packet-level model.
module tb_spi_draw_decoder;

  localparam int HALF = 5;

  logic       clk;
  logic       reset;
  logic       sck;
  logic       sdi;
  logic       cs;
  logic       sdo;
  logic [9:0] x;
  logic [9:0] y;
  logic [2:0] newColor;
  logic       brush;
  logic       ready;
  logic       error;
  logic [1:0] dbg_state_o;

  spi_draw_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .sck         (sck),
    .sdi         (sdi),
    .cs          (cs),
    .sdo         (sdo),
    .x           (x),
    .y           (y),
    .newColor    (newColor),
    .brush       (brush),
    .ready       (ready),
    .error       (error),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters and checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [7:0]  frame_q[$];
  logic        exp_sdo[$];
  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];
  logic [9:0]  m_x = '0;
  logic [9:0]  m_y = '0;
  logic [2:0]  m_col = '0;
  logic        m_brush = 1'b0;
  logic        m_err = 1'b0;

  // Walk the frame packet by packet: expected MISO bits, accepted pixels, error flag.
  task automatic model_frame(input int nbits);
    logic [7:0] b0, b1, b2, b3, status;
    logic [9:0] mx, my;
    int p, avail;
    exp_sdo.delete();
    p = 0;
    while (p * 32 < nbits) begin
      avail  = nbits - p * 32;
      b0     = frame_q[4 * p];
      status = {m_err, 7'b0000001};
      for (int i = 0; i < 32 && i < avail; i++) exp_sdo.push_back(i < 8 ? status[7 - i] : 1'b0);
      if (avail < 8) break;
      if (b0[7:6] != 2'b10) begin
        m_err = 1'b1;
        for (int i = 32; i < avail; i++) exp_sdo.push_back(1'b0);
        break;
      end
      if (avail < 32) break;
      b1 = frame_q[4 * p + 1];
      b2 = frame_q[4 * p + 2];
      b3 = frame_q[4 * p + 3];
      mx = {b1[7:6], b2};
      my = {b1[5:4], b3};
      if (int'(mx) < 640 && int'(my) < 480) begin
        m_x = mx; m_y = my; m_col = b0[4:2]; m_brush = b0[5]; m_err = 1'b0;
        exp_q.push_back({m_brush, m_col, m_x, m_y});
      end else begin
        m_err = 1'b1;
      end
      p++;
    end
  endtask

  // ---------------- monitor ----------------
  int   last_rise_cyc = 0;
  logic ready_prev = 1'b0;

  always @(negedge clk) begin
    int lat;
    if (ready_prev) check_eq("ready_width", ready, 1'b0);
    if (ready) begin
      lat = cyc - last_rise_cyc;
      check_eq("ready_latency_in_3_to_6", (lat >= 3 && lat <= 6), 1'b1);
      got_q.push_back({brush, newColor, x, y});
    end
    ready_prev = ready;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic b, output logic sdo_seen);
    sdi = b;
    repeat (HALF) @(negedge clk);
    sdo_seen = sdo;
    sck = 1'b1;
    last_rise_cyc = cyc;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic push_pkt(input logic [1:0] hdr, input logic br, input logic [2:0] col,
                          input logic [9:0] px, input logic [9:0] py, input bit rsv);
    logic [1:0] r0;
    logic [3:0] r1;
    r0 = rsv ? 2'($urandom) : 2'b00;
    r1 = rsv ? 4'($urandom) : 4'b0000;
    frame_q.push_back({hdr, br, col, r0});
    frame_q.push_back({px[9:8], py[9:8], r1});
    frame_q.push_back(px[7:0]);
    frame_q.push_back(py[7:0]);
  endtask

  task automatic scoreboard(input string tag);
    check_eq({tag, "_ready_cnt"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check_eq({tag, "_pixel"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
    check_eq({tag, "_x"}, x, m_x);
    check_eq({tag, "_y"}, y, m_y);
    check_eq({tag, "_color"}, newColor, m_col);
    check_eq({tag, "_brush"}, brush, m_brush);
    check_eq({tag, "_error"}, error, m_err);
    check_eq({tag, "_state_idle"}, dbg_state_o, 2'd0);
  endtask

  task automatic send_frame(input string tag, input int nbits);
    logic seen;
    model_frame(nbits);
    cs = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      drive_bit(frame_q[k / 8][7 - (k % 8)], seen);
      check_eq({tag, "_sdo"}, seen, exp_sdo[k]);
    end
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (12) @(negedge clk);
    scoreboard(tag);
  endtask

  task automatic reset_and_check(input string tag);
    reset = 1'b1;
    @(negedge clk);
    check_eq({tag, "_x"}, x, 10'd0);
    check_eq({tag, "_y"}, y, 10'd0);
    check_eq({tag, "_color"}, newColor, 3'd0);
    check_eq({tag, "_brush"}, brush, 1'b0);
    check_eq({tag, "_ready"}, ready, 1'b0);
    check_eq({tag, "_error"}, error, 1'b0);
    check_eq({tag, "_sdo"}, sdo, 1'b0);
    check_eq({tag, "_state"}, dbg_state_o, 2'd0);
    reset = 1'b0;
    m_x = '0; m_y = '0; m_col = '0; m_brush = 1'b0; m_err = 1'b0;
  endtask

  // Reset lands mid-packet; the rest of the frame has no fresh cs fall and must be ignored.
  task automatic reset_mid_frame(input int bits_before);
    logic seen;
    cs = 1'b0;
    for (int k = 0; k < bits_before; k++) drive_bit(frame_q[k / 8][7 - (k % 8)], seen);
    reset_and_check("rst_mid");
    for (int k = bits_before; k < 32; k++) drive_bit(frame_q[k / 8][7 - (k % 8)], seen);
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (12) @(negedge clk);
    scoreboard("rst_mid_after");
  endtask

  task automatic rand_pkt();
    int kind;
    logic [1:0] hdr;
    logic [9:0] px, py;
    kind = $urandom_range(0, 9);
    hdr  = 2'b10;
    px   = 10'($urandom_range(0, 639));
    py   = 10'($urandom_range(0, 479));
    case (kind)
      0: hdr = 2'($urandom_range(0, 2)) ^ 2'b01;
      1: px  = 10'($urandom_range(640, 1023));
      2: py  = 10'($urandom_range(480, 1023));
      3: begin px = 10'd639; py = 10'd479; end
      default: ;
    endcase
    push_pkt(hdr, 1'($urandom), 3'($urandom), px, py, 1'b1);
  endtask

  // ---------------- timeout ----------------
  initial begin
    #900_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int npk, nb, total;
    reset = 1'b1;
    cs    = 1'b1;
    sck   = 1'b0;
    sdi   = 1'b0;
    repeat (4) @(negedge clk);
    reset_and_check("por");
    repeat (4) @(negedge clk);

    frame_q = '{8'h94, 8'h00, 8'h0A, 8'h14};
    send_frame("basic", 32);

    frame_q = '{8'h94, 8'h90, 8'h7F, 8'hDF};
    send_frame("x639_y479", 32);
    frame_q = '{8'h94, 8'h90, 8'h80, 8'hDF};
    send_frame("x640", 32);
    frame_q = '{8'h88, 8'h10, 8'h05, 8'hE0};
    send_frame("y480", 32);
    frame_q = '{8'h88, 8'hC0, 8'hFF, 8'h01};
    send_frame("x1023", 32);

    frame_q = '{8'h54, 8'h00, 8'h0A, 8'h14, 8'h94, 8'h00, 8'h0B, 8'h15};
    send_frame("bad_hdr", 64);
    frame_q = '{8'hA8, 8'h50, 8'h21, 8'h33};
    send_frame("after_bad", 32);

    frame_q = '{8'h94, 8'h00, 8'h0A, 8'h14, 8'h8C, 8'h10, 8'h64, 8'h32};
    send_frame("two_pkts", 64);

    frame_q = '{8'h94, 8'h90, 8'h80, 8'hDF};
    send_frame("err_set", 32);
    frame_q = '{8'h94, 8'h00, 8'h0A, 8'h14};
    send_frame("abort20", 20);
    frame_q = '{8'hB0, 8'h40, 8'h12, 8'h34};
    send_frame("after_abort", 32);

    frame_q = '{8'h94, 8'h00, 8'h0A, 8'h14};
    reset_mid_frame(12);
    frame_q = '{8'h94, 8'h00, 8'h0A, 8'h14};
    send_frame("pre_rst", 32);
    reset_and_check("rst_after_pkt");
    frame_q = '{8'h9C, 8'h20, 8'h44, 8'h55};
    send_frame("post_rst", 32);

    for (int f = 0; f < 30; f++) begin
      frame_q.delete();
      npk = $urandom_range(1, 3);
      for (int p = 0; p < npk; p++) rand_pkt();
      total = npk * 32;
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, total - 1)) : total;
      send_frame("rand", nb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
